// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard-control bus: hazard/event inputs from the pipeline and
// stage enable/clear outputs back to the pipeline registers.
interface pipe_ctrl_if;
    // hazard and event inputs
    logic        i_miss;
    logic        d_miss;
    logic        load_use;
    logic        branch_taken;
    logic        div_start;
    logic        div_done;
    logic        except_req;

    // stage register controls and status
    logic        en_f;
    logic        en_d;
    logic        en_e;
    logic        en_m;
    logic        en_w;
    logic        clr_d;
    logic        clr_e;
    logic        clr_m;
    logic        clr_w;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    // pipeline side: raises hazards, consumes enables/clears
    modport master (
        output i_miss, d_miss, load_use, branch_taken, div_start, div_done, except_req,
        input  en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w, state, stall_cycles
    );

    // controller side
    modport slave (
        input  i_miss, d_miss, load_use, branch_taken, div_start, div_done, except_req,
        output en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w, state, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller. Stage enables and clears are a
// combinational decode of the current state and the hazard inputs; only the
// FSM state and the stall performance counter are registered.
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DIV   = 2'd1,
        MEM   = 2'd2,
        XPEND = 2'd3
    } state_t;

    // en = {f, d, e, m, w}, clr = {d, e, m, w}
    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_FRONT = 5'b00111;   // freeze fetch/decode
    localparam logic [4:0] EN_DIV   = 5'b00011;   // freeze fetch/decode/execute
    localparam logic [3:0] CLR_NONE = 4'b0000;
    localparam logic [3:0] CLR_ALL  = 4'b1111;    // exception flush
    localparam logic [3:0] CLR_D    = 4'b1000;
    localparam logic [3:0] CLR_E    = 4'b0100;
    localparam logic [3:0] CLR_M    = 4'b0010;
    localparam logic [3:0] CLR_W    = 4'b0001;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  en;
    logic [3:0]  clr;
    logic [31:0] stall_q;

    // Output decode and next-state selection, prioritised per state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        en      = EN_ALL;
        clr     = CLR_NONE;
        state_d = state_q;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (bus.except_req) begin
                        // an exception behind a D-cache refill must wait for it
                        if (bus.d_miss) begin
                            en      = EN_NONE;
                            state_d = XPEND;
                        end else begin
                            clr = CLR_ALL;
                        end
                    end else if (bus.d_miss) begin
                        en      = EN_NONE;
                        clr     = CLR_W;
                        state_d = MEM;
                    end else if (bus.div_start) begin
                        en      = EN_DIV;
                        clr     = CLR_M;
                        state_d = DIV;
                    end else if (bus.i_miss) begin
                        en  = EN_FRONT;
                        clr = CLR_E;
                    end else if (bus.load_use) begin
                        // a taken branch still kills the wrong-path decode slot
                        en  = EN_FRONT;
                        clr = bus.branch_taken ? (CLR_E | CLR_D) : CLR_E;
                    end else if (bus.branch_taken) begin
                        clr = CLR_D;
                    end
                end
                DIV: begin
                    if (bus.except_req) begin
                        clr     = CLR_ALL;
                        state_d = RUN;
                    end else if (bus.div_done) begin
                        state_d = RUN;
                    end else begin
                        // d_miss is deliberately ignored here; RUN re-evaluates it
                        en  = EN_DIV;
                        clr = CLR_M;
                    end
                end
                MEM: begin
                    if (bus.except_req) begin
                        en      = EN_NONE;
                        clr     = CLR_W;
                        state_d = XPEND;
                    end else if (bus.d_miss) begin
                        en  = EN_NONE;
                        clr = CLR_W;
                    end else begin
                        state_d = RUN;
                    end
                end
                XPEND: begin
                    // further exception pulses are absorbed: one flush only
                    if (bus.d_miss) begin
                        en = EN_NONE;
                    end else begin
                        clr     = CLR_ALL;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register and saturating stall counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (!en[4] && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign bus.en_f         = en[4];
    assign bus.en_d         = en[3];
    assign bus.en_e         = en[2];
    assign bus.en_m         = en[1];
    assign bus.en_w         = en[0];
    assign bus.clr_d        = clr[3];
    assign bus.clr_e        = clr[2];
    assign bus.clr_m        = clr[1];
    assign bus.clr_w        = clr[0];
    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a table of single-cycle vectors applied
// from RUN, plus hand-written multi-cycle sequences. Expected values are
// pushed to a scoreboard queue when stimulus is driven and popped when the
// outputs are sampled on the falling edge.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // input bit positions: {i_miss, d_miss, load_use, branch_taken, div_start, div_done, except_req}
    localparam logic [6:0] IM = 7'h40;
    localparam logic [6:0] DM = 7'h20;
    localparam logic [6:0] LU = 7'h10;
    localparam logic [6:0] BR = 7'h08;
    localparam logic [6:0] DS = 7'h04;
    localparam logic [6:0] DD = 7'h02;
    localparam logic [6:0] XR = 7'h01;

    // outputs as {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w}
    localparam logic [8:0] O_DEF   = 9'b11111_0000;
    localparam logic [8:0] O_FLUSH = 9'b11111_1111;
    localparam logic [8:0] O_FRZ   = 9'b00000_0000;
    localparam logic [8:0] O_MEM   = 9'b00000_0001;
    localparam logic [8:0] O_DIV   = 9'b00011_0010;
    localparam logic [8:0] O_STALL = 9'b00111_0100;
    localparam logic [8:0] O_BR    = 9'b11111_1000;
    localparam logic [8:0] O_LUBR  = 9'b00111_1100;

    localparam logic [1:0] S_RUN = 2'd0, S_DIV = 2'd1, S_MEM = 2'd2, S_XP = 2'd3;

    typedef struct {
        string      name;
        logic [6:0] in;
        logic [8:0] outs;
        logic [1:0] nxt;
    } vec_t;

    typedef struct {
        logic [8:0] outs;
        logic [1:0] nxt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] v);
        bus.i_miss       = v[6];
        bus.d_miss       = v[5];
        bus.load_use     = v[4];
        bus.branch_taken = v[3];
        bus.div_start    = v[2];
        bus.div_done     = v[1];
        bus.except_req   = v[0];
    endtask

    function automatic logic [8:0] outs();
        return {bus.en_f, bus.en_d, bus.en_e, bus.en_m, bus.en_w,
                bus.clr_d, bus.clr_e, bus.clr_m, bus.clr_w};
    endfunction

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input string name, input logic [6:0] in,
                        input logic [8:0] exp_o, input logic [1:0] exp_s);
        exp_t e;
        e.outs = exp_o;
        e.nxt  = exp_s;
        sb.push_back(e);
        set_in(in);
        @(negedge clk);
        e = sb.pop_front();
        check({name, " outs"}, 32'(outs()), 32'(e.outs));
        @(posedge clk);
        #1;
        check({name, " state"}, 32'(bus.state), 32'(e.nxt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(7'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{"idle",           7'h00,             O_DEF,   S_RUN},
            '{"exc",            XR,                O_FLUSH, S_RUN},
            '{"exc+dmiss",      XR | DM,           O_FRZ,   S_XP},
            '{"dmiss",          DM,                O_MEM,   S_MEM},
            '{"div_start",      DS,                O_DIV,   S_DIV},
            '{"imiss",          IM,                O_STALL, S_RUN},
            '{"load_use",       LU,                O_STALL, S_RUN},
            '{"branch",         BR,                O_BR,    S_RUN},
            '{"lu+branch",      LU | BR,           O_LUBR,  S_RUN},
            '{"exc+div+br",     XR | DS | BR,      O_FLUSH, S_RUN},
            '{"dmiss+div",      DM | DS,           O_MEM,   S_MEM},
            '{"div+imiss",      DS | IM,           O_DIV,   S_DIV},
            '{"imiss+lu+br",    IM | LU | BR,      O_STALL, S_RUN},
            '{"all-but-exc",    7'h7E,             O_MEM,   S_MEM}
        };

        // reset behaviour with every input asserted
        rst = 1'b1;
        set_in(7'h00);
        repeat (2) @(posedge clk);
        set_in(7'h7F);
        @(negedge clk);
        check("rst outs", 32'(outs()), 32'(O_DEF));
        check("rst state", 32'(bus.state), 32'(S_RUN));
        check("rst stall", bus.stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(7'h00);
        check("post-rst state", 32'(bus.state), 32'(S_RUN));

        // table-driven single-cycle vectors from RUN
        foreach (vecs[i]) begin
            do_reset();
            step(vecs[i].name, vecs[i].in, vecs[i].outs, vecs[i].nxt);
            check({vecs[i].name, " stall"}, bus.stall_cycles,
                  vecs[i].outs[8] ? 32'd0 : 32'd1);
        end

        // load_use single-cycle stall
        do_reset();
        step("lu seq", LU, O_STALL, S_RUN);
        step("lu seq idle", 7'h00, O_DEF, S_RUN);
        check("lu seq stall", bus.stall_cycles, 32'd1);

        // divide: issue, four waiting cycles, done
        do_reset();
        step("div issue", DS, O_DIV, S_DIV);
        for (int k = 1; k <= 4; k++) step($sformatf("div wait%0d", k), 7'h00, O_DIV, S_DIV);
        step("div done", DD, O_DEF, S_RUN);
        step("div after", 7'h00, O_DEF, S_RUN);
        check("div stall", bus.stall_cycles, 32'd5);

        // refill with exception in second cycle: one flush after refill ends
        do_reset();
        step("xp c0", DM, O_MEM, S_MEM);
        step("xp c1", DM | XR, O_MEM, S_XP);
        step("xp c2", DM, O_FRZ, S_XP);
        step("xp c3", 7'h00, O_FLUSH, S_RUN);
        step("xp c4", 7'h00, O_DEF, S_RUN);
        check("xp stall", bus.stall_cycles, 32'd3);

        // repeated exception pulses while pending are absorbed
        do_reset();
        step("abs c0", DM | XR, O_FRZ, S_XP);
        step("abs c1", DM | XR, O_FRZ, S_XP);
        step("abs c2", 7'h00, O_FLUSH, S_RUN);
        step("abs c3", 7'h00, O_DEF, S_RUN);

        // exception abandons a divide
        do_reset();
        step("dx issue", DS, O_DIV, S_DIV);
        step("dx exc", XR | DM, O_FLUSH, S_RUN);

        // d_miss inside DIV holds DIV, then re-evaluated in RUN
        do_reset();
        step("dm issue", DS, O_DIV, S_DIV);
        step("dm hold", DM, O_DIV, S_DIV);
        step("dm done", DD | DM, O_DEF, S_RUN);
        step("dm run", DM, O_MEM, S_MEM);
        step("dm exit", 7'h00, O_DEF, S_RUN);

        // reset during DIV
        do_reset();
        step("rd issue", DS, O_DIV, S_DIV);
        step("rd wait", 7'h00, O_DIV, S_DIV);
        rst = 1'b1;
        set_in(7'h7F);
        @(negedge clk);
        check("rd rst outs", 32'(outs()), 32'(O_DEF));
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(7'h00);
        check("rd state", 32'(bus.state), 32'(S_RUN));
        check("rd stall", bus.stall_cycles, 32'd0);
        step("rd idle", 7'h00, O_DEF, S_RUN);

        // counter saturation from a preloaded value
        do_reset();
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        check("sat preload", bus.stall_cycles, 32'hFFFF_FFFE);
        for (int k = 1; k <= 3; k++) begin
            step($sformatf("sat stall%0d", k), LU, O_STALL, S_RUN);
            check($sformatf("sat count%0d", k), bus.stall_cycles, 32'hFFFF_FFFF);
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
